// File: rtl/hom_pkg.sv
// Shared definitions for the hit-or-miss game blocks.
//   state_e   : judge FSM states
//   LED_W     : number of LEDs / buttons
//   is_onehot : true when exactly one bit of an LED vector is set
package hom_pkg;

  localparam int unsigned LED_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    OVER  = 2'd2
  } state_e;

  function automatic logic is_onehot(input logic [LED_W-1:0] v);
    return (v != '0) && ((v & (v - LED_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge detect.
//   clk, rst : clock, asynchronous active-high reset
//   btn_i    : raw asynchronous buttons
//   edge_o   : one-cycle pulse per press, 3 cycles after btn_i rises
module btn_sync_edge #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] btn_i,
  output logic [W-1:0] edge_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] sync_dly_q;
  logic [W-1:0] edge_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q     <= '0;
      sync_q     <= '0;
      sync_dly_q <= '0;
      edge_q     <= '0;
    end else begin
      meta_q     <= btn_i;
      sync_q     <= meta_q;
      sync_dly_q <= sync_q;
      edge_q     <= sync_q & ~sync_dly_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/hit_judge.sv
// Hit-or-miss round judge: lights the presented target, opens a timed
// response window, judges button presses, and keeps score / miss count.
//   clk, rst     : clock, asynchronous active-high reset
//   target_valid : one-cycle pulse, new target presented
//   target       : one-hot target LED (sampled with target_valid)
//   btn          : raw asynchronous player buttons
//   led_on       : LED drive (0 idle, target when armed, all on when over)
//   hit_pulse    : one-cycle pulse, round won
//   miss_pulse   : one-cycle pulse, round lost
//   score        : saturating hit counter
//   misses       : miss counter
//   game_over    : high once misses reaches MAX_MISSES
module hit_judge
  import hom_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 100000000,
  parameter int unsigned MAX_MISSES    = 3,
  parameter int unsigned SCORE_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               target_valid,
  input  logic [LED_W-1:0]   target,
  input  logic [LED_W-1:0]   btn,
  output logic [LED_W-1:0]   led_on,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         misses,
  output logic               game_over
);

  localparam int unsigned        TMR_W     = $clog2(WINDOW_CYCLES) + 1;
  localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [3:0]         MISS_LAST = 4'(MAX_MISSES - 1);

  state_e             state_q, state_d;
  logic [LED_W-1:0]   tgt_q, tgt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         misses_q, misses_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;

  logic [LED_W-1:0]   btn_edge;
  logic               new_ok;

  btn_sync_edge #(.W(LED_W)) u_btn (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn),
    .edge_o (btn_edge)
  );

  assign new_ok = target_valid && is_onehot(target);

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    timer_d  = timer_q;
    score_d  = score_q;
    misses_d = misses_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (new_ok) begin
          tgt_d   = target;
          timer_d = '0;
          state_d = ARMED;
        end
      end

      ARMED: begin
        timer_d = timer_q + TMR_W'(1);

        // Press beats timeout beats abandonment; a press arriving with a
        // new target is judged against the target already latched.
        if (btn_edge != '0) begin
          if (btn_edge == tgt_q) hit_d = 1'b1;
          else                   miss_d = 1'b1;
        end else if (timer_q == TMR_LAST) begin
          miss_d = 1'b1;
        end else if (target_valid) begin
          miss_d = 1'b1;
        end

        if (hit_d || miss_d) begin
          if (hit_d && (score_q != SCORE_MAX)) score_d = score_q + SCORE_W'(1);
          if (miss_d) misses_d = misses_q + 4'd1;

          if (miss_d && (misses_q == MISS_LAST)) begin
            state_d = OVER;
          end else if (new_ok) begin
            tgt_d   = target;
            timer_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      OVER: begin
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tgt_q    <= '0;
      timer_q  <= '0;
      score_q  <= '0;
      misses_q <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      timer_q  <= timer_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  always_comb begin
    case (state_q)
      ARMED:   led_on = tgt_q;
      OVER:    led_on = '1;
      default: led_on = '0;
    endcase
  end

  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign score      = score_q;
  assign misses     = misses_q;
  assign game_over  = (state_q == OVER);

endmodule

// File: tb/tb_hit_judge.sv
// Randomised scoreboard bench for hit_judge. Two instances share stimulus:
// one with an 8-bit score, one with a 2-bit score for saturation.
module tb_hit_judge;

  localparam int unsigned W    = 16;
  localparam int unsigned MAXM = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       target_valid;
  logic [7:0] target;
  logic [7:0] btn;

  logic [7:0] led_on, led_on2;
  logic       hit_pulse, miss_pulse, hit2, miss2;
  logic [7:0] score;
  logic [1:0] score2;
  logic [3:0] misses, misses2;
  logic       game_over, game_over2;

  hit_judge #(.WINDOW_CYCLES(W), .MAX_MISSES(MAXM), .SCORE_W(8)) dut (
    .clk(clk), .rst(rst), .target_valid(target_valid), .target(target),
    .btn(btn), .led_on(led_on), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .score(score), .misses(misses), .game_over(game_over)
  );

  hit_judge #(.WINDOW_CYCLES(W), .MAX_MISSES(MAXM), .SCORE_W(2)) dut_s (
    .clk(clk), .rst(rst), .target_valid(target_valid), .target(target),
    .btn(btn), .led_on(led_on2), .hit_pulse(hit2), .miss_pulse(miss2),
    .score(score2), .misses(misses2), .game_over(game_over2)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Round-level reference model
  typedef struct {
    bit          is_hit;
    int unsigned cyc;
    int unsigned score;
    int unsigned misses;
    bit          over;
    logic [7:0]  led;
  } exp_t;

  exp_t        q[$];
  int unsigned m_score  = 0;
  int unsigned m_misses = 0;
  bit          m_over   = 0;

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic push_exp(input bit is_hit, input int unsigned c, input logic [7:0] led_after);
    exp_t e;
    if (is_hit) m_score++;
    else begin
      m_misses++;
      if (m_misses == MAXM) m_over = 1;
    end
    e.is_hit = is_hit;
    e.cyc    = c;
    e.score  = m_score;
    e.misses = m_misses;
    e.over   = m_over;
    e.led    = m_over ? 8'hFF : led_after;
    q.push_back(e);
  endtask

  // Monitor: pops an expectation whenever either DUT pulses
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++; failures++;
        $display("FAIL missing_pulse: got none expected %s at cycle %0d",
                 q[0].is_hit ? "hit" : "miss", q[0].cyc);
        void'(q.pop_front());
      end
      if (hit_pulse || miss_pulse) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
          e = q.pop_front();
          chk("pulse_kind", {hit_pulse, miss_pulse}, e.is_hit ? 2'b10 : 2'b01);
          chk("score", score, sat(e.score, 255));
          chk("misses", misses, e.misses);
          chk("game_over", game_over, e.over);
          chk("led_after", led_on, e.led);
          chk("pulse_kind_s", {hit2, miss2}, e.is_hit ? 2'b10 : 2'b01);
          chk("score_sat", score2, sat(e.score, 3));
          chk("misses_s", misses2, e.misses);
        end else begin
          checks++; failures++;
          $display("FAIL unexpected_pulse: got hit=%0b miss=%0b expected none (cycle %0d)",
                   hit_pulse, miss_pulse, cyc);
        end
      end else if (hit2 || miss2) begin
        checks++; failures++;
        $display("FAIL unexpected_pulse_s: got hit=%0b miss=%0b expected none (cycle %0d)",
                 hit2, miss2, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) tick();
  endtask

  task automatic start_target(input logic [7:0] t);
    target       = t;
    target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
    target       = '0;
  endtask

  function automatic logic [7:0] onehot_rand();
    logic [7:0] one;
    one = 8'h01;
    return one << $urandom_range(0, 7);
  endfunction

  function automatic logic [7:0] other_than(input logic [7:0] t);
    logic [7:0] o;
    do o = onehot_rand(); while (o == t);
    return o;
  endfunction

  // Target, then a press of pattern p issued d cycles after target_valid
  task automatic press_round(input logic [7:0] t, input logic [7:0] p, input int unsigned d);
    int unsigned t0, p0;
    t0 = cyc;
    start_target(t);
    chk("armed_led", led_on, m_over ? 8'hFF : t);
    wait_until(t0 + d);
    btn = p;
    p0  = cyc;
    if (!m_over) push_exp(p == t, p0 + 4, 8'h00);
    repeat ($urandom_range(1, 6)) tick();
    btn = '0;
    wait_until(p0 + 9);
  endtask

  task automatic timeout_round(input logic [7:0] t);
    int unsigned t0;
    t0 = cyc;
    start_target(t);
    if (!m_over) push_exp(1'b0, t0 + 1 + W, 8'h00);
    wait_until(t0 + W + 4);
  endtask

  // Second target d cycles into the round, then no press
  task automatic abandon_round(input logic [7:0] t1, input logic [7:0] t2, input int unsigned d);
    int unsigned t0, a;
    t0 = cyc;
    start_target(t1);
    wait_until(t0 + d);
    a = cyc;
    start_target(t2);
    if (!m_over) begin
      push_exp(1'b0, a + 1, t2);
      if (!m_over) push_exp(1'b0, a + 1 + W, 8'h00);
    end
    wait_until(a + W + 4);
  endtask

  task automatic bad_target_round(input logic [7:0] t, input bit press);
    start_target(t);
    if (press) begin
      btn = onehot_rand();
      tick(); tick();
      btn = '0;
    end
    repeat (6) tick();
    chk("bad_target_led", led_on, m_over ? 8'hFF : 8'h00);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_led"}, led_on, 0);
    chk({tag, "_pulses"}, {hit_pulse, miss_pulse, hit2, miss2}, 0);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_misses"}, misses, 0);
    chk({tag, "_over"}, {game_over, game_over2}, 0);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero(tag);
    q.delete();
    m_score = 0; m_misses = 0; m_over = 0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic random_round();
    logic [7:0] t;
    int unsigned k;
    t = onehot_rand();
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2, 3, 4: press_round(t, t, $urandom_range(1, W - 3));
      5:       press_round(t, other_than(t), $urandom_range(1, W - 3));
      6:       press_round(t, t | other_than(t), $urandom_range(1, W - 3));
      7:       timeout_round(t);
      8:       abandon_round(t, onehot_rand(), $urandom_range(1, W - 1));
      default: bad_target_round(t | other_than(t), 1'b1);
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0, guard;
    rst = 1'b1; target_valid = 1'b0; target = '0; btn = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Game 1
    press_round(8'h04, 8'h04, 5);
    chk("idle_led_after_hit", led_on, 0);
    bad_target_round(8'h03, 1'b1);
    bad_target_round(8'h00, 1'b0);
    timeout_round(8'h10);
    press_round(8'h01, 8'h08, 4);
    abandon_round(8'h02, 8'h40, 4);
    chk("over_led", led_on, 8'hFF);
    chk("over_flag", game_over, 1);
    press_round(8'h08, 8'h08, 3);
    timeout_round(8'h20);
    chk("over_score_frozen", score, 1);
    chk("over_misses_frozen", misses, 3);
    async_reset("rst_from_over");

    // Game 2: saturation, timer restart on abandonment, reset mid-round
    repeat (5) begin
      logic [7:0] t;
      t = onehot_rand();
      press_round(t, t, $urandom_range(1, W - 3));
    end
    press_round(8'h80, 8'h80, W - 3);
    abandon_round(8'h02, 8'h40, 4);
    t0 = cyc;
    start_target(8'h20);
    repeat (4) tick();
    async_reset("rst_mid_round");
    wait_until(t0 + W + 6);
    chk("no_pulse_after_abort", led_on, 0);

    // Game 3: random play until over
    press_round(8'h01, 8'h03, 6);
    for (int r = 0; r < 40 && !m_over; r++) random_round();
    for (int r = 0; r < 3 && !m_over; r++) timeout_round(onehot_rand());
    chk("final_over_flag", {game_over, game_over2}, 2'b11);

    guard = 0;
    while (q.size() > 0 && guard < 200) begin tick(); guard++; end
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hit_judge.md
Name: hit_judge

Overview:
- Downstream of the LED randomizer in the hit-or-miss game.
- Takes each new one-hot target LED, lights it, and opens a timed response window.
- Synchronises the raw player buttons and judges each round as a hit or a miss.
- Keeps the score and miss count, and ends the game after MAX_MISSES misses.

Parameters:
- WINDOW_CYCLES, 100000000: response window length in clk cycles (1 s at 100 MHz).
- MAX_MISSES, 3: miss count that ends the game (range 1..15).
- SCORE_W, 8: score counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- target_valid  in  1  one-cycle pulse in the clk domain: a new target is presented.
- target  in  8  one-hot target LED; sampled when target_valid=1.
- btn  in  8  raw asynchronous player buttons, one per LED.
- led_on  out  8  LED drive.
- hit_pulse  out  1  one-cycle pulse: round won.
- miss_pulse  out  1  one-cycle pulse: round lost.
- score  out  SCORE_W  number of hits.
- misses  out  4  number of misses.
- game_over  out  1  high once misses reaches MAX_MISSES.

Behaviour:
- Reset values: state=IDLE; led_on, hit_pulse, miss_pulse, score, misses, game_over, the timer and the latched target all 0; synchroniser flops 0.
- Reset asserted mid-round aborts the round with no pulse.
- Button path:
  - btn goes through a 2-flop synchroniser, then a registered rising-edge detect (edge = sync & ~sync_d).
  - A press shows up in edge 3 cycles after btn rises.
  - Held buttons produce one edge only.
- IDLE:
  - led_on=0; edges are ignored.
  - target_valid with exactly one bit of target set: latch target, timer=0, go to ARMED.
  - target_valid with a non-one-hot target (0 or more than one bit set) is ignored.
- ARMED:
  - led_on = latched target; timer increments by 1 each cycle.
  - Decision priority per cycle, highest first:
    1. edge!=0: hit if edge == latched target exactly; any other non-zero edge (wrong LED, or correct LED plus another) is a miss.
    2. timer == WINDOW_CYCLES-1: timeout miss.
    3. target_valid: the current round counts as a miss (abandoned).
  - If edge and target_valid occur in the same cycle, the edge is judged against the old target.
  - After any decision: if target_valid is high that cycle with a one-hot target, re-arm with the new target (timer=0, stay ARMED); otherwise go to IDLE.
- Result outputs:
  - hit_pulse / miss_pulse are registered and high for exactly the cycle after the decision cycle; never both high.
  - score increments on a hit and saturates at 2^SCORE_W-1.
  - misses increments on a miss.
  - The miss that makes misses == MAX_MISSES also moves state to OVER; game_over rises in the same cycle as that miss_pulse.
- OVER:
  - led_on=8'hFF, game_over=1.
  - target_valid and btn are ignored; score and misses are frozen.
  - Only rst leaves OVER.
- Timer width: $clog2(WINDOW_CYCLES)+1 bits; the timer cannot wrap, because the timeout fires at WINDOW_CYCLES-1.

Decomposition:
- Package hom_pkg:
  - state enum {IDLE, ARMED, OVER};
  - LED_W=8 constant;
  - is_onehot function (shared with the randomizer and its checks).
- Sub-module btn_sync_edge:
  - parameter W;
  - 2-flop synchroniser plus registered rising-edge detect;
  - reusable for the start/reset buttons.
- The FSM, timer and counters stay in hit_judge.

Test Plan (bench uses WINDOW_CYCLES=16, MAX_MISSES=3):
- target_valid with target=8'h04; raise btn[2] 5 cycles later:
  - led_on=8'h04 from the next cycle;
  - hit_pulse exactly once, 4 cycles after btn rises;
  - score=1; led_on=0 afterwards.
- target=8'h10, no press:
  - miss_pulse in the cycle after timer==15;
  - misses=1; led_on returns to 0.
- target=8'h01, press btn[3]:
  - miss_pulse; score unchanged.
- Repeat with btn[0]|btn[1] pressed in the same cycle:
  - still a miss.
- target=8'h03 or 8'h00 with target_valid:
  - stays IDLE; led_on=0; no pulses.
- In ARMED on 8'h02, second target_valid with 8'h40 and no press:
  - miss_pulse; led_on=8'h40; timer restarts (the timeout arrives a full 16 cycles later).
- Three misses in a row:
  - game_over=1 alongside the third miss_pulse; led_on=8'hFF.
  - Further targets and presses change nothing.
  - Assert rst mid-stream: all outputs return to 0 asynchronously.
- Score saturation with SCORE_W=2:
  - 5 hits leave score=3.
